exe_stage: RTL and testbench

Execute stage of the in-order RV32I pipeline. It consumes the pipe #4 operands and controls from the issue stage and computes ALU, LUI/AUIPC and link results, memory addresses and branch/jump outcomes. It drives the PC redirect to fetch, squashes younger in-flight instructions after a redirect, and registers pipe #5 for the memory/commit stage.

---
 rtl/exe_stage.sv | 157 +++++++++++++++
 tb/tb_exe_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : exe_stage                                                        |
// | Brief   : RV32I execute stage: ALU, branch/jump resolution, PC redirect,   |
// |           younger-instruction squash and pipe #5 register.                 |
// | Option  : define EXE_MISALIGN_EN to suppress redirects to targets with     |
// |           bit1 set and flag them through misalign5.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module exe_stage #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid4,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] rs2_data4,
  input  logic [3:0]  alu_fn4,
  input  logic [3:0]  fn4,
  input  logic        btype4,
  input  logic        j4,
  input  logic        jr4,
  input  logic        LUI4,
  input  logic        auipc4,
  input  logic        we4,
  input  logic [4:0]  rd4,
  input  logic [3:0]  mem_op4,
  input  logic [31:0] pc4,
  input  logic [31:0] B_imm4,
  input  logic [31:0] J_imm4,
  input  logic [31:0] U_imm4,
  input  logic [31:0] S_imm4,
  input  logic [31:0] I_imm4,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        we5,
  output logic [4:0]  rd5,
  output logic [31:0] result5,
  output logic [3:0]  mem_op5,
  output logic [31:0] mem_addr5,
  output logic [31:0] store_data5,
  output logic [31:0] pc5,
  output logic        misalign5
);

  localparam logic [1:0] c_squash_load = 2'(SQUASH_DEPTH);

  logic [1:0]  r_squash_cnt;
  logic        w_live;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_cond;
  logic        w_taken;
  logic        w_misalign;
  logic [4:0]  w_shamt;
  logic        w_unused;

  assign w_live     = valid4 & (r_squash_cnt == 2'd0);
  assign w_shamt    = op_b[4:0];
  assign w_pc_plus4 = pc4 + 32'd4;
  assign w_unused   = fn4[3];

  always_comb begin
    w_alu = op_a + op_b;
    case (alu_fn4)
      4'b1000: w_alu = op_a - op_b;
      4'b0001: w_alu = op_a << w_shamt;
      4'b0010: w_alu = {31'd0, $signed(op_a) < $signed(op_b)};
      4'b0011: w_alu = {31'd0, op_a < op_b};
      4'b0100: w_alu = op_a ^ op_b;
      4'b0101: w_alu = op_a >> w_shamt;
      4'b1101: w_alu = $unsigned($signed(op_a) >>> w_shamt);
      4'b0110: w_alu = op_a | op_b;
      4'b0111: w_alu = op_a & op_b;
      default: w_alu = op_a + op_b;
    endcase
  end

  always_comb begin
    if (j4 | jr4)
      w_result = w_pc_plus4;
    else if (LUI4)
      w_result = U_imm4;
    else if (auipc4)
      w_result = pc4 + U_imm4;
    else
      w_result = w_alu;
  end

  always_comb begin
    w_cond = 1'b0;
    case (fn4[2:0])
      3'b000:  w_cond = (op_a == op_b);
      3'b001:  w_cond = (op_a != op_b);
      3'b100:  w_cond = ($signed(op_a) <  $signed(op_b));
      3'b101:  w_cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  w_cond = (op_a <  op_b);
      3'b111:  w_cond = (op_a >= op_b);
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    if (jr4)
      w_target = (op_a + I_imm4) & 32'hFFFF_FFFE;
    else if (j4)
      w_target = pc4 + J_imm4;
    else
      w_target = pc4 + B_imm4;
  end

  assign w_taken = w_live & (j4 | jr4 | (btype4 & w_cond));

`ifdef EXE_MISALIGN_EN
  assign w_misalign = w_taken & w_target[1];
`else
  assign w_misalign = 1'b0;
`endif

  // Gated with nrst so fetch never sees a redirect while the pipe is held in reset.
  assign redirect    = nrst & w_taken & ~w_misalign;
  assign redirect_pc = w_taken ? w_target : w_pc_plus4;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_squash_cnt <= 2'd0;
      we5          <= 1'b0;
      rd5          <= 5'd0;
      result5      <= 32'd0;
      mem_op5      <= 4'd0;
      mem_addr5    <= 32'd0;
      store_data5  <= 32'd0;
      pc5          <= 32'd0;
      misalign5    <= 1'b0;
    end else begin
      // Bubbles pass through without consuming a squash slot.
      if (w_taken)
        r_squash_cnt <= c_squash_load;
      else if (valid4 && (r_squash_cnt != 2'd0))
        r_squash_cnt <= r_squash_cnt - 2'd1;

      we5         <= w_live & we4 & ~btype4 & ~w_misalign;
      rd5         <= rd4;
      result5     <= w_result;
      mem_op5     <= w_live ? mem_op4 : 4'd0;
      mem_addr5   <= mem_op4[3] ? (op_a + S_imm4) : w_alu;
      store_data5 <= rs2_data4;
      pc5         <= pc4;
      misalign5   <= w_misalign;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_exe_stage                                                     |
// | Brief   : Directed self-checking bench for exe_stage.                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid4;
  logic [31:0] op_a, op_b, rs2_data4;
  logic [3:0]  alu_fn4, fn4;
  logic        btype4, j4, jr4, LUI4, auipc4, we4;
  logic [4:0]  rd4;
  logic [3:0]  mem_op4;
  logic [31:0] pc4, B_imm4, J_imm4, U_imm4, S_imm4, I_imm4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        we5;
  logic [4:0]  rd5;
  logic [31:0] result5;
  logic [3:0]  mem_op5;
  logic [31:0] mem_addr5, store_data5, pc5;
  logic        misalign5;

  int tests = 0;
  int fails = 0;

  exe_stage #(.SQUASH_DEPTH(2)) dut (
    .clk(clk), .nrst(nrst), .valid4(valid4), .op_a(op_a), .op_b(op_b),
    .rs2_data4(rs2_data4), .alu_fn4(alu_fn4), .fn4(fn4), .btype4(btype4),
    .j4(j4), .jr4(jr4), .LUI4(LUI4), .auipc4(auipc4), .we4(we4), .rd4(rd4),
    .mem_op4(mem_op4), .pc4(pc4), .B_imm4(B_imm4), .J_imm4(J_imm4),
    .U_imm4(U_imm4), .S_imm4(S_imm4), .I_imm4(I_imm4),
    .redirect(redirect), .redirect_pc(redirect_pc), .we5(we5), .rd5(rd5),
    .result5(result5), .mem_op5(mem_op5), .mem_addr5(mem_addr5),
    .store_data5(store_data5), .pc5(pc5), .misalign5(misalign5)
  );

  always #5 clk = ~clk;

  // Plain valid ADD x5 = 0 + 0 at pc 0x800.
  task automatic nop();
    valid4 = 1'b1; op_a = 32'd0; op_b = 32'd0; rs2_data4 = 32'd0;
    alu_fn4 = 4'b0000; fn4 = 4'b0010; btype4 = 1'b0; j4 = 1'b0; jr4 = 1'b0;
    LUI4 = 1'b0; auipc4 = 1'b0; we4 = 1'b1; rd4 = 5'd5; mem_op4 = 4'd0;
    pc4 = 32'h800; B_imm4 = 32'd0; J_imm4 = 32'd0; U_imm4 = 32'd0;
    S_imm4 = 32'd0; I_imm4 = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    nop();
    j4 = 1'b1; J_imm4 = 32'h40;
    #12;
    tests++;
    if (redirect !== 1'b0) begin
      fails++; $display("FAIL reset_redirect: got %b want 0", redirect);
    end
    tests++;
    if ({we5, rd5, result5, mem_op5, mem_addr5, store_data5, pc5, misalign5} !== 139'd0) begin
      fails++; $display("FAIL reset_outputs: got we5=%b result5=%h pc5=%h want all zero", we5, result5, pc5);
    end
    nop();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    nop(); alu_fn4 = 4'b1000; op_a = 32'd5; op_b = 32'd7; rd4 = 5'd3;
    tick();
    tests++;
    if (result5 !== 32'hFFFF_FFFE || we5 !== 1'b1 || rd5 !== 5'd3) begin
      fails++; $display("FAIL alu_sub: got %h we5=%b rd5=%0d want fffffffe 1 3", result5, we5, rd5);
    end
    nop(); alu_fn4 = 4'b1101; op_a = 32'h8000_0000; op_b = 32'd4;
    tick();
    tests++;
    if (result5 !== 32'hF800_0000) begin
      fails++; $display("FAIL alu_sra: got %h want f8000000", result5);
    end
    nop(); alu_fn4 = 4'b0011; op_a = 32'd1; op_b = 32'hFFFF_FFFF;
    tick();
    tests++;
    if (result5 !== 32'd1) begin
      fails++; $display("FAIL alu_sltu: got %h want 1", result5);
    end
    nop(); alu_fn4 = 4'b0010; op_a = 32'hFFFF_FFFF; op_b = 32'd1;
    tick();
    tests++;
    if (result5 !== 32'd1) begin
      fails++; $display("FAIL alu_slt: got %h want 1", result5);
    end
    nop(); alu_fn4 = 4'b1010; op_a = 32'h10; op_b = 32'h22;
    tick();
    tests++;
    if (result5 !== 32'h32) begin
      fails++; $display("FAIL alu_default_add: got %h want 32", result5);
    end
    nop(); LUI4 = 1'b1; U_imm4 = 32'h1234_5000; op_a = 32'h7;
    tick();
    tests++;
    if (result5 !== 32'h1234_5000) begin
      fails++; $display("FAIL lui: got %h want 12345000", result5);
    end
    nop(); auipc4 = 1'b1; pc4 = 32'h1000; U_imm4 = 32'h2000;
    tick();
    tests++;
    if (result5 !== 32'h3000 || pc5 !== 32'h1000) begin
      fails++; $display("FAIL auipc: got %h pc5=%h want 3000 1000", result5, pc5);
    end
  endtask

  task automatic test_beq_squash();
    nop(); fn4 = 4'b0001; btype4 = 1'b1; op_a = 32'd3; op_b = 32'd3; pc4 = 32'h200;
    #1;
    tests++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h204) begin
      fails++; $display("FAIL bne_not_taken: got %b %h want 0 204", redirect, redirect_pc);
    end
    fn4 = 4'b0000; pc4 = 32'h100; B_imm4 = 32'h20;
    #1;
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h120) begin
      fails++; $display("FAIL beq_redirect: got %b %h want 1 120", redirect, redirect_pc);
    end
    tick();
    tests++;
    if (we5 !== 1'b0) begin
      fails++; $display("FAIL beq_no_writeback: got we5=%b want 0", we5);
    end
    for (int i = 0; i < 3; i++) begin
      nop(); mem_op4 = 4'd2;
      tick();
      tests++;
      if (i < 2 && (we5 !== 1'b0 || mem_op5 !== 4'd0)) begin
        fails++; $display("FAIL beq_squash_%0d: got we5=%b mem_op5=%h want 0 0", i, we5, mem_op5);
      end else if (i == 2 && (we5 !== 1'b1 || mem_op5 !== 4'd2)) begin
        fails++; $display("FAIL beq_after_squash: got we5=%b mem_op5=%h want 1 2", we5, mem_op5);
      end
    end
  endtask

  task automatic test_jal();
    nop(); j4 = 1'b1; pc4 = 32'h40; J_imm4 = 32'h100; rd4 = 5'd1;
    #1;
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h140) begin
      fails++; $display("FAIL jal_redirect: got %b %h want 1 140", redirect, redirect_pc);
    end
    tick();
    tests++;
    if (result5 !== 32'h44 || we5 !== 1'b1 || rd5 !== 5'd1) begin
      fails++; $display("FAIL jal_link: got %h we5=%b rd5=%0d want 44 1 1", result5, we5, rd5);
    end
    nop(); tick(); tick();
  endtask

  task automatic test_jalr();
    nop(); jr4 = 1'b1; op_a = 32'h203; I_imm4 = 32'd0;
    #1;
    tests++;
`ifdef EXE_MISALIGN_EN
    if (redirect !== 1'b0 || redirect_pc !== 32'h202) begin
      fails++; $display("FAIL jalr_redirect: got %b %h want 0 202", redirect, redirect_pc);
    end
`else
    if (redirect !== 1'b1 || redirect_pc !== 32'h202) begin
      fails++; $display("FAIL jalr_redirect: got %b %h want 1 202", redirect, redirect_pc);
    end
`endif
    tick();
    tests++;
`ifdef EXE_MISALIGN_EN
    if (misalign5 !== 1'b1 || we5 !== 1'b0) begin
      fails++; $display("FAIL jalr_misalign: got misalign5=%b we5=%b want 1 0", misalign5, we5);
    end
`else
    if (misalign5 !== 1'b0 || we5 !== 1'b1 || result5 !== 32'h804) begin
      fails++; $display("FAIL jalr_link: got misalign5=%b we5=%b %h want 0 1 804", misalign5, we5, result5);
    end
`endif
    nop(); tick();
    tests++;
    if (we5 !== 1'b0) begin
      fails++; $display("FAIL jalr_squash: got we5=%b want 0", we5);
    end
    tick();
  endtask

  task automatic test_squash_bubbles();
    nop(); btype4 = 1'b1; fn4 = 4'b0000; pc4 = 32'h300; B_imm4 = 32'h10;
    tick();
    for (int i = 0; i < 2; i++) begin
      nop(); valid4 = 1'b0;
      tick();
    end
    nop(); btype4 = 1'b1; fn4 = 4'b0000;
    #1;
    tests++;
    if (redirect !== 1'b0) begin
      fails++; $display("FAIL squashed_branch_redirect: got %b want 0", redirect);
    end
    tick();
    nop();
    tick();
    tests++;
    if (we5 !== 1'b0) begin
      fails++; $display("FAIL bubble_second_kill: got we5=%b want 0", we5);
    end
    nop();
    tick();
    tests++;
    if (we5 !== 1'b1) begin
      fails++; $display("FAIL bubble_third_live: got we5=%b want 1", we5);
    end
    nop(); j4 = 1'b1; pc4 = 32'h500; J_imm4 = 32'h8;
    #1;
    tests++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h508) begin
      fails++; $display("FAIL redirect_after_drain: got %b %h want 1 508", redirect, redirect_pc);
    end
    tick();
    nop(); tick(); tick();
  endtask

  task automatic test_store();
    nop(); mem_op4 = 4'h8; op_a = 32'h1000; S_imm4 = 32'hFFFF_FFFC;
    rs2_data4 = 32'hDEAD_BEEF; we4 = 1'b0; op_b = 32'h55;
    tick();
    tests++;
    if (mem_addr5 !== 32'hFFC || store_data5 !== 32'hDEAD_BEEF || mem_op5 !== 4'h8 || we5 !== 1'b0) begin
      fails++; $display("FAIL store: got addr=%h data=%h op=%h we5=%b want ffc deadbeef 8 0", mem_addr5, store_data5, mem_op5, we5);
    end
    nop(); mem_op4 = 4'h2; op_a = 32'h10; op_b = 32'h4; S_imm4 = 32'h100;
    tick();
    tests++;
    if (mem_addr5 !== 32'h14 || mem_op5 !== 4'h2) begin
      fails++; $display("FAIL load_addr: got %h op=%h want 14 2", mem_addr5, mem_op5);
    end
  endtask

  task automatic test_reset_mid_squash();
    nop(); j4 = 1'b1; pc4 = 32'h40; J_imm4 = 32'h100; rd4 = 5'd1;
    tick();
    nop(); rs2_data4 = 32'h1234;
    tick();
    nop(); j4 = 1'b1;
    nrst = 1'b0;
    #1;
    tests++;
    if ({we5, rd5, result5, mem_op5, mem_addr5, store_data5, pc5, misalign5} !== 139'd0 || redirect !== 1'b0) begin
      fails++; $display("FAIL reset_mid_squash: got result5=%h pc5=%h store=%h redirect=%b want all zero", result5, pc5, store_data5, redirect);
    end
    nop();
    nrst = 1'b1;
    tick();
    tests++;
    if (we5 !== 1'b1) begin
      fails++; $display("FAIL reset_clears_counter: got we5=%b want 1", we5);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_beq_squash();
    test_jal();
    test_jalr();
    test_squash_bubbles();
    test_store();
    test_reset_mid_squash();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
